nipcb_stim_seq: RTL and testbench
=================================

# nipcb_stim_seq

Parametrised multi-channel biphasic stimulation sequencer. It is the next generation of the single-channel NIPCB stimulation core and sits between the NIPCB register file and the SPI DAC master. On a trigger it latches a shadow copy of the timing and magnitude registers, enables one of `NCH` electrode channels, and issues a DAC write at every phase boundary over a valid/ready handshake. It then times each phase in `CLK` cycles and raises done/IRQ on completion.

## Interface
Parameters:
- `NCH`, 4: number of stimulation channels, ≥2.
- `CNT_W`, 32: width of all cycle counters and the pulse count.
- `MAG_W`, 16: DAC code width.
- `MAG_IDLE`, 16'h8000: DAC code written in DELAY, STALL and PARK (zero-current midscale).

Ports:
- `CLK`, in, 1: clock.
- `RESETn`, in, 1: synchronous, active-low reset.
- `trigger`, in, 1: one-cycle start pulse.
- `abort`, in, 1: one-cycle stop pulse.
- `ch_sel`, in, `$clog2(NCH)`: target channel.
- `cyc_delay`, `cyc_high`, `cyc_low`, `cyc_stall`, in, `CNT_W` each: phase durations in cycles.
- `pulse_count`, in, `CNT_W`: number of biphasic pulses.
- `mag_high`, `mag_low`, in, `MAG_W` each: DAC codes for the HIGH and LOW phases.
- `dac_valid`, out, 1: DAC write request.
- `dac_data`, out, `MAG_W`: DAC code.
- `dac_ready`, in, 1: SPI master accepts the write.
- `en_ch`, out, `NCH`: one-hot channel enable.
- `sel_ch`, out, `$clog2(NCH)`: latched channel index.
- `running`, out, 1: sequence active.
- `done`, out, 1: one-cycle completion pulse.
- `pulses_left`, out, `CNT_W`: remaining pulses, including the current one.
- `IRQ`, out, 1: completion interrupt.

## Operation
- States: IDLE, DELAY, HIGH, LOW, STALL, PARK. Every non-IDLE state has two substates: WR, where `dac_valid` is high and the block waits for `dac_ready`, then CNT, where the phase timer runs.
- IDLE: a `trigger` with `pulse_count` ≠ 0 latches all inputs into shadow registers and enters DELAY.
  - If the latched `cyc_delay` = 0, the block enters HIGH instead.
  - A `trigger` with `pulse_count` = 0 is ignored.
  - A `trigger` received while `running` is high is ignored.
- Write codes by state: DELAY, STALL and PARK write `MAG_IDLE`. HIGH writes the shadow `mag_high`. LOW writes the shadow `mag_low`.
- Transitions:
  - DELAY goes to HIGH.
  - HIGH goes to LOW.
  - LOW decrements `pulses_left`. If the result is 0 the block goes to PARK. Otherwise it goes to STALL, or directly to HIGH when `cyc_stall` = 0.
  - STALL goes to HIGH.
  - PARK goes to IDLE as soon as its handshake completes, with no timer.
- A HIGH or LOW phase with a duration of 0 is treated as 1 cycle.
- `dac_data` is held stable while `dac_valid` is high. `dac_valid` never drops before `dac_ready` is seen.
- `abort` in any non-IDLE state goes to PARK/WR. If a write is pending, the pending write completes first and PARK is then issued. `abort` in PARK or IDLE is ignored.
- `en_ch` equals `1 << sel_ch` from DELAY entry until PARK completes, and is 0 otherwise. `running` follows the same window.
- Shadow registers are immune to input changes while running.
- Counters are unsigned, `CNT_W` bits wide, and never wrap: the phase timer counts down to 1.

## Timing
- Reset values: `dac_valid`=0, `dac_data`=`MAG_IDLE`, `en_ch`=0, `sel_ch`=0, `running`=0, `done`=0, `pulses_left`=0, `IRQ`=0, state IDLE.
- Trigger sampled in cycle T: `running`, `en_ch` and the first `dac_valid` are all high at T+1.
- Handshake (`dac_valid` & `dac_ready`) in cycle H: the next state's `dac_valid` rises at H+N, where N is the phase duration. With `dac_ready` tied high, a pulse period is exactly high+low+stall cycles.
- PARK handshake in cycle P: `running`=0, `en_ch`=0 and the `done` pulse all occur at P+1.
- If `trigger` and `abort` arrive in the same cycle while in IDLE, `trigger` wins.
- Reset mid-sequence returns everything to the reset values on the next edge. No PARK write is issued.

## Configuration
- `NIPCB_STIM_IRQ_EN` defined: `IRQ` is a sticky level set together with `done` and cleared by the next accepted `trigger`. An aborted sequence also sets it.
- `NIPCB_STIM_IRQ_EN` undefined: `IRQ` is tied to 1'b0 and no sticky register is generated.

## Structure
- Package `nipcb_stim_pkg` holds the state enum `stim_state_t` and the default `MAG_IDLE` constant.
- Sub-module `nipcb_phase_timer` (`CNT_W`-bit load/count-down/expire) is instantiated once and reloaded at each handshake.

## Test plan
- Nominal run, `dac_ready`=1: delay=3, high=2, low=2, stall=4, count=2, ch=2, mag_high=0xC000, mag_low=0x4000.
  - Required DAC sequence: 8000, C000, 4000, 8000, C000, 4000, 8000.
  - The HIGH writes are 8 cycles apart.
  - `en_ch`=4'b0100 throughout, then `done` pulses once.
- Backpressure: hold `dac_ready` low for 5 cycles on the first HIGH write.
  - `dac_valid` and `dac_data` stay stable throughout.
  - All later phase edges shift by exactly 5 cycles.
- Abort during the second HIGH phase: a single 8000 write follows, then `running`=0 and `done`=1. `pulses_left` is 2 at abort time.
- Zero fields: count=0 trigger gives no `dac_valid` and `running` stays 0. delay=0 makes the first write C000 at T+1. stall=0 produces back-to-back LOW→HIGH.
- Shadow and re-trigger: changing `mag_high` and `ch_sel` mid-run has no effect, and a second `trigger` while running is ignored.
- Reset at random cycles returns all outputs to their reset values. With `NIPCB_STIM_IRQ_EN`, `IRQ` sets at completion and clears on the next trigger.

Source files
------------

// File: rtl/nipcb_stim_pkg.sv
// nipcb_stim_pkg: shared types and constants for the NIPCB stimulation sequencer.
//   stim_state_t     - sequencer phase encoding
//   MAG_IDLE_DEFAULT - zero-current midscale DAC code
package nipcb_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_STALL = 3'd4,
        ST_PARK  = 3'd5
    } stim_state_t;

    localparam logic [15:0] MAG_IDLE_DEFAULT = 16'h8000;

endpackage

// File: rtl/nipcb_phase_timer.sv
// nipcb_phase_timer: CNT_W-bit load / count-down / expire timer.
// Ports:
//   CLK, RESETn      - clock, synchronous active-low reset
//   load, load_val   - load a new count (takes priority over en)
//   en               - decrement while count > 1
//   expire           - count has reached 1 (or is idle at 0)
module nipcb_phase_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;

    // Saturates at 1 so the counter can never wrap.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q > CNT_W'(1))) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign expire = (count_q <= CNT_W'(1));

endmodule

// File: rtl/nipcb_stim_seq.sv
// nipcb_stim_seq: multi-channel biphasic stimulation sequencer.
// On trigger, latches timing/magnitude shadows, enables one channel and walks
// DELAY -> (HIGH -> LOW -> STALL)* -> PARK, issuing one DAC write per phase over
// a valid/ready handshake and timing each phase with a shared phase timer.
// Ports:
//   CLK, RESETn                              - clock, synchronous active-low reset
//   trigger, abort                           - one-cycle start / stop pulses
//   ch_sel                                   - target channel
//   cyc_delay/high/low/stall, pulse_count    - phase durations, pulse count
//   mag_high, mag_low                        - DAC codes for HIGH / LOW
//   dac_valid, dac_data, dac_ready           - DAC write handshake
//   en_ch, sel_ch                            - one-hot enable, latched channel
//   running, done, pulses_left, IRQ          - status
// Build option: define NIPCB_STIM_IRQ_EN for a sticky completion IRQ; otherwise IRQ = 0.
module nipcb_stim_seq
    import nipcb_stim_pkg::*;
#(
    parameter int unsigned     NCH      = 4,
    parameter int unsigned     CNT_W    = 32,
    parameter int unsigned     MAG_W    = 16,
    parameter logic [MAG_W-1:0] MAG_IDLE = MAG_W'(MAG_IDLE_DEFAULT)
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic                    trigger,
    input  logic                    abort,
    input  logic [$clog2(NCH)-1:0]  ch_sel,
    input  logic [CNT_W-1:0]        cyc_delay,
    input  logic [CNT_W-1:0]        cyc_high,
    input  logic [CNT_W-1:0]        cyc_low,
    input  logic [CNT_W-1:0]        cyc_stall,
    input  logic [CNT_W-1:0]        pulse_count,
    input  logic [MAG_W-1:0]        mag_high,
    input  logic [MAG_W-1:0]        mag_low,
    output logic                    dac_valid,
    output logic [MAG_W-1:0]        dac_data,
    input  logic                    dac_ready,
    output logic [NCH-1:0]          en_ch,
    output logic [$clog2(NCH)-1:0]  sel_ch,
    output logic                    running,
    output logic                    done,
    output logic [CNT_W-1:0]        pulses_left,
    output logic                    IRQ
);

    stim_state_t state_q, state_d;
    logic        wr_q, wr_d;               // 1: WR substate, 0: CNT substate
    logic        abort_pend_q, abort_pend_d;
    logic        done_q, done_d;

    logic [$clog2(NCH)-1:0] sel_q;
    logic [CNT_W-1:0] sh_delay_q, sh_high_q, sh_low_q, sh_stall_q, pulses_q;
    logic [MAG_W-1:0] sh_mag_high_q, sh_mag_low_q;

    logic             latch, dec_pulse;
    logic             hs;
    logic             t_load, t_en, t_expire;
    logic [CNT_W-1:0] t_val, dur;
    stim_state_t      nxt;

    assign hs = wr_q & dac_ready;

    // Duration of the current phase; HIGH/LOW of 0 behave as 1 cycle.
    always_comb begin
        dur = CNT_W'(1);
        unique case (state_q)
            ST_DELAY: dur = sh_delay_q;
            ST_HIGH:  dur = (sh_high_q == '0) ? CNT_W'(1) : sh_high_q;
            ST_LOW:   dur = (sh_low_q == '0) ? CNT_W'(1) : sh_low_q;
            ST_STALL: dur = sh_stall_q;
            default:  dur = CNT_W'(1);
        endcase
    end

    // Phase that follows the current one when its timer runs out.
    always_comb begin
        nxt = ST_PARK;
        unique case (state_q)
            ST_DELAY: nxt = ST_HIGH;
            ST_HIGH:  nxt = ST_LOW;
            ST_LOW: begin
                if (pulses_q == CNT_W'(1))  nxt = ST_PARK;
                else if (sh_stall_q == '0)  nxt = ST_HIGH;
                else                        nxt = ST_STALL;
            end
            ST_STALL: nxt = ST_HIGH;
            default:  nxt = ST_PARK;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        abort_pend_d = abort_pend_q;
        done_d       = 1'b0;
        latch        = 1'b0;
        dec_pulse    = 1'b0;
        t_load       = 1'b0;
        t_val        = '0;
        t_en         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger && (pulse_count != '0)) begin
                    latch        = 1'b1;
                    state_d      = (cyc_delay == '0) ? ST_HIGH : ST_DELAY;
                    wr_d         = 1'b1;
                    abort_pend_d = 1'b0;
                end
            end
            ST_PARK: begin
                if (hs) begin
                    state_d = ST_IDLE;
                    wr_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                if (wr_q) begin
                    if (hs) begin
                        if (abort || abort_pend_q) begin
                            state_d      = ST_PARK;
                            abort_pend_d = 1'b0;
                        end else if (dur == CNT_W'(1)) begin
                            // One-cycle phase: straight into the next write.
                            state_d   = nxt;
                            dec_pulse = (state_q == ST_LOW);
                        end else begin
                            // Loaded with dur-1 so the next valid rises dur cycles after hs.
                            wr_d   = 1'b0;
                            t_load = 1'b1;
                            t_val  = dur - CNT_W'(1);
                        end
                    end else if (abort) begin
                        abort_pend_d = 1'b1;
                    end
                end else begin
                    t_en = 1'b1;
                    if (abort) begin
                        state_d = ST_PARK;
                        wr_d    = 1'b1;
                    end else if (t_expire) begin
                        state_d   = nxt;
                        wr_d      = 1'b1;
                        dec_pulse = (state_q == ST_LOW);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q       <= ST_IDLE;
            wr_q          <= 1'b0;
            abort_pend_q  <= 1'b0;
            done_q        <= 1'b0;
            sel_q         <= '0;
            sh_delay_q    <= '0;
            sh_high_q     <= '0;
            sh_low_q      <= '0;
            sh_stall_q    <= '0;
            pulses_q      <= '0;
            sh_mag_high_q <= '0;
            sh_mag_low_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            abort_pend_q <= abort_pend_d;
            done_q       <= done_d;
            if (latch) begin
                sel_q         <= ch_sel;
                sh_delay_q    <= cyc_delay;
                sh_high_q     <= cyc_high;
                sh_low_q      <= cyc_low;
                sh_stall_q    <= cyc_stall;
                pulses_q      <= pulse_count;
                sh_mag_high_q <= mag_high;
                sh_mag_low_q  <= mag_low;
            end else if (dec_pulse) begin
                pulses_q <= pulses_q - CNT_W'(1);
            end
        end
    end

    nipcb_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .load     (t_load),
        .load_val (t_val),
        .en       (t_en),
        .expire   (t_expire)
    );

    // Shadows are frozen while running, so dac_data is stable across a stalled write.
    always_comb begin
        dac_data = MAG_IDLE;
        unique case (state_q)
            ST_HIGH: dac_data = sh_mag_high_q;
            ST_LOW:  dac_data = sh_mag_low_q;
            default: dac_data = MAG_IDLE;
        endcase
    end

    assign dac_valid   = wr_q;
    assign running     = (state_q != ST_IDLE);
    assign en_ch       = running ? (NCH'(1) << sel_q) : '0;
    assign sel_ch      = sel_q;
    assign done        = done_q;
    assign pulses_left = pulses_q;

`ifdef NIPCB_STIM_IRQ_EN
    logic irq_q;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            irq_q <= 1'b0;
        end else if (done_d) begin
            irq_q <= 1'b1;
        end else if (latch) begin
            irq_q <= 1'b0;
        end
    end

    assign IRQ = irq_q;
`else
    assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_nipcb_stim_seq.sv
// Scoreboard bench for nipcb_stim_seq: stimulus pushes expected DAC writes
// (code + cycle) and done cycles; monitors pop and compare on each handshake.
module tb_nipcb_stim_seq;

    localparam int NCH   = 4;
    localparam int CNT_W = 32;
    localparam int MAG_W = 16;

`ifdef NIPCB_STIM_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RESETn = 1'b0;
    logic             trigger = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       ch_sel = '0;
    logic [CNT_W-1:0] cyc_delay = '0, cyc_high = '0, cyc_low = '0, cyc_stall = '0;
    logic [CNT_W-1:0] pulse_count = '0;
    logic [MAG_W-1:0] mag_high = '0, mag_low = '0;
    logic             dac_valid;
    logic [MAG_W-1:0] dac_data;
    logic             dac_ready = 1'b1;
    logic [NCH-1:0]   en_ch;
    logic [1:0]       sel_ch;
    logic             running, done, IRQ;
    logic [CNT_W-1:0] pulses_left;

    nipcb_stim_seq #(
        .NCH   (NCH),
        .CNT_W (CNT_W),
        .MAG_W (MAG_W)
    ) dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .trigger     (trigger),
        .abort       (abort),
        .ch_sel      (ch_sel),
        .cyc_delay   (cyc_delay),
        .cyc_high    (cyc_high),
        .cyc_low     (cyc_low),
        .cyc_stall   (cyc_stall),
        .pulse_count (pulse_count),
        .mag_high    (mag_high),
        .mag_low     (mag_low),
        .dac_valid   (dac_valid),
        .dac_data    (dac_data),
        .dac_ready   (dac_ready),
        .en_ch       (en_ch),
        .sel_ch      (sel_ch),
        .running     (running),
        .done        (done),
        .pulses_left (pulses_left),
        .IRQ         (IRQ)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [MAG_W-1:0] data;
        int               at;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Write monitor: data and cycle of every handshake, plus hold-stability under backpressure.
    logic             stalled = 1'b0;
    logic [MAG_W-1:0] stalled_data = '0;
    always @(negedge CLK) begin
        if (!RESETn) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 64'(dac_valid), 64'(1));
                chk("hold_data", 64'(dac_data), 64'(stalled_data));
            end
            if (dac_valid && dac_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(dac_data), 64'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_data", 64'(dac_data), 64'(e.data));
                    chk("wr_cycle", 64'(cyc), 64'(e.at));
                end
            end
            stalled      = dac_valid && !dac_ready;
            stalled_data = dac_data;
        end
    end

    always @(negedge CLK) begin
        if (RESETn && done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
                int d;
                d = done_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(d));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Returns the cycle T in which trigger is sampled; exits at cycle T+1.
    task automatic fire(output int t);
        step(1);
        trigger = 1'b1;
        t = cyc;
        step(1);
        trigger = 1'b0;
    endtask

    task automatic exp_wr(input logic [MAG_W-1:0] d, input int at);
        exp_t e;
        e.data = d;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            step(1);
            n++;
        end
        if (n >= budget) begin
            chk("drain_timeout", 64'(exp_q.size() + done_q.size()), 64'(0));
            exp_q.delete();
            done_q.delete();
        end
        step(2);
    endtask

    task automatic cfg(input int d, input int h, input int l, input int s, input int c,
                       input logic [1:0] ch);
        cyc_delay   = CNT_W'(d);
        cyc_high    = CNT_W'(h);
        cyc_low     = CNT_W'(l);
        cyc_stall   = CNT_W'(s);
        pulse_count = CNT_W'(c);
        ch_sel      = ch;
        mag_high    = 16'hC000;
        mag_low     = 16'h4000;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, 64'(dac_valid), 64'(0));
        chk({tag, "_data"}, 64'(dac_data), 64'h8000);
        chk({tag, "_en_ch"}, 64'(en_ch), 64'(0));
        chk({tag, "_sel_ch"}, 64'(sel_ch), 64'(0));
        chk({tag, "_running"}, 64'(running), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_pulses"}, 64'(pulses_left), 64'(0));
        chk({tag, "_irq"}, 64'(IRQ), 64'(0));
    endtask

    // Nominal schedule (delay 3, high 2, low 2, stall 4, count 2) shifted by bp stall cycles.
    task automatic push_nominal(input int t, input int bp);
        exp_wr(16'h8000, t + 1);
        exp_wr(16'hC000, t + 4 + bp);
        exp_wr(16'h4000, t + 6 + bp);
        exp_wr(16'h8000, t + 8 + bp);
        exp_wr(16'hC000, t + 12 + bp);
        exp_wr(16'h4000, t + 14 + bp);
        exp_wr(16'h8000, t + 16 + bp);
        done_q.push_back(t + 17 + bp);
    endtask

    initial begin
        int t;

        step(3);
        check_reset("reset");
        RESETn = 1'b1;
        step(2);

        // Nominal run
        cfg(3, 2, 2, 4, 2, 2'd2);
        fire(t);
        push_nominal(t, 0);
        chk("nom_running", 64'(running), 64'(1));
        chk("nom_en_ch_start", 64'(en_ch), 64'b0100);
        chk("nom_valid_t1", 64'(dac_valid), 64'(1));
        step(6);
        chk("nom_en_ch_mid", 64'(en_ch), 64'b0100);
        drain(60);
        chk("nom_running_end", 64'(running), 64'(0));
        chk("nom_en_ch_end", 64'(en_ch), 64'(0));
        chk("nom_pulses_end", 64'(pulses_left), 64'(0));
        chk("nom_irq", 64'(IRQ), 64'(IRQ_EN));

        // Backpressure: first HIGH write held off for 5 cycles
        fire(t);
        push_nominal(t, 5);
        step(3);
        dac_ready = 1'b0;
        step(5);
        dac_ready = 1'b1;
        drain(60);

        // Abort in second HIGH phase
        cfg(3, 2, 2, 4, 3, 2'd1);
        fire(t);
        exp_wr(16'h8000, t + 1);
        exp_wr(16'hC000, t + 4);
        exp_wr(16'h4000, t + 6);
        exp_wr(16'h8000, t + 8);
        exp_wr(16'hC000, t + 12);
        exp_wr(16'h8000, t + 14);
        done_q.push_back(t + 15);
        step(12);
        chk("abort_pulses_left", 64'(pulses_left), 64'(2));
        chk("abort_en_ch", 64'(en_ch), 64'b0010);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        drain(40);
        chk("abort_running_end", 64'(running), 64'(0));
        chk("abort_irq", 64'(IRQ), 64'(IRQ_EN));

        // Zero pulse count: trigger ignored
        cfg(3, 2, 2, 4, 0, 2'd3);
        fire(t);
        chk("zero_cnt_running", 64'(running), 64'(0));
        chk("zero_cnt_valid", 64'(dac_valid), 64'(0));
        step(4);
        chk("zero_cnt_running_late", 64'(running), 64'(0));

        // Zero delay, zero high (acts as 1), zero stall
        cfg(0, 0, 2, 0, 2, 2'd0);
        fire(t);
        chk("d0_first_data", 64'(dac_data), 64'hC000);
        exp_wr(16'hC000, t + 1);
        exp_wr(16'h4000, t + 2);
        exp_wr(16'hC000, t + 4);
        exp_wr(16'h4000, t + 5);
        exp_wr(16'h8000, t + 7);
        done_q.push_back(t + 8);
        drain(40);

        // Shadow immunity and ignored re-trigger
        cfg(3, 2, 2, 4, 2, 2'd2);
        chk("pre_retrig_irq", 64'(IRQ), 64'(IRQ_EN));
        fire(t);
        push_nominal(t, 0);
        chk("retrig_irq_clear", 64'(IRQ), 64'(0));
        step(1);
        mag_high    = 16'h1111;
        ch_sel      = 2'd0;
        cyc_high    = CNT_W'(7);
        pulse_count = CNT_W'(9);
        step(2);
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        step(5);
        chk("shadow_en_ch", 64'(en_ch), 64'b0100);
        chk("shadow_sel_ch", 64'(sel_ch), 64'(2));
        drain(60);
        chk("shadow_pulses_end", 64'(pulses_left), 64'(0));

        // Reset at random points mid-sequence
        cfg(3, 2, 2, 4, 2, 2'd2);
        for (int i = 0; i < 3; i++) begin
            fire(t);
            push_nominal(t, 0);
            step($urandom_range(1, 14));
            RESETn = 1'b0;
            step(1);
            exp_q.delete();
            done_q.delete();
            check_reset("midreset");
            RESETn = 1'b1;
            step(4);
            chk("midreset_no_park", 64'(dac_valid), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
